// File: rtl/comm_pkg.sv
// Shared constants and FSM state type for the UART command frame controller.
package comm_pkg;

   localparam logic [7:0] TYPE_WRITE = 8'h01;
   localparam logic [7:0] TYPE_STEP  = 8'h02;
   localparam logic [7:0] TYPE_RANGE = 8'h03;
   localparam logic [7:0] TYPE_PING  = 8'h04;

   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   localparam logic [11:0] STEP_RST  = 12'd1;
   localparam logic [11:0] RANGE_RST = 12'hfff;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_TYPE,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_DATA,
      ST_CFG_HI,
      ST_CFG_LO,
      ST_DRAIN,
      ST_RESP
   } state_t;

endpackage

// File: rtl/comm_word_assembler.sv
// Shifts received bytes MSB-first into a table word and pulses word_done
// the cycle after the word's last byte; word holds steady until the next word.
module comm_word_assembler #(
   parameter int unsigned OUTPUT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    byte_valid,
   input  logic [7:0]              byte_data,
   output logic                    word_done,
   output logic [OUTPUT_WIDTH-1:0] word
);

   localparam int unsigned BPW = OUTPUT_WIDTH / 8;

   logic [OUTPUT_WIDTH-1:0] shift_reg;
   logic [OUTPUT_WIDTH-1:0] shifted;
   logic [1:0]              byte_idx;

   assign shifted = (shift_reg << 8) | OUTPUT_WIDTH'(byte_data);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg <= '0;
         byte_idx  <= '0;
         word      <= '0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;
         if (clear) begin
            shift_reg <= '0;
            byte_idx  <= '0;
         end else if (byte_valid) begin
            if (byte_idx == 2'(BPW - 1)) begin
               word      <= shifted;
               word_done <= 1'b1;
               shift_reg <= '0;
               byte_idx  <= '0;
            end else begin
               shift_reg <= shifted;
               byte_idx  <= byte_idx + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/comm_frame_ctrl.sv
// Length-prefixed command frame parser: table writes, step/range updates,
// one ACK/NAK per frame, inter-byte timeout recovery.
module comm_frame_ctrl
   import comm_pkg::*;
#(
   parameter int unsigned OUTPUT_WIDTH   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   input  logic                    tx_busy,
   output logic                    tx_send,
   output logic [7:0]              tx_data,
   output logic                    wr_enable,
   output logic [11:0]             wr_addr,
   output logic [OUTPUT_WIDTH-1:0] wr_data,
   output logic [11:0]             step,
   output logic [11:0]             range,
   output logic                    overrun
);

   localparam int unsigned BPW = OUTPUT_WIDTH / 8;
   localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 2);

   state_t          state, next_state;
   logic [7:0]      rem;
   logic [7:0]      next_resp;
   logic [CW-1:0]   idle_cnt;
   logic [3:0]      addr_hi;
   logic [3:0]      cfg_hi;
   logic            cfg_range;
   logic            timeout_hit;
   logic            write_len_ok;
   logic            last_byte;
   logic            in_frame;
   logic [7:0]      pay_len;

   assign in_frame     = (state != ST_IDLE) && (state != ST_RESP);
   assign last_byte    = (rem == 8'd1);
   assign pay_len      = rem - 8'd3;
   assign write_len_ok = (rem > 8'd3) && ((pay_len % 8'(BPW)) == 8'd0);
   // A byte arriving on the expiry cycle wins, so the timeout needs !rx_valid.
   assign timeout_hit  = in_frame && !rx_valid && (idle_cnt == TO_LAST);

   comm_word_assembler #(.OUTPUT_WIDTH(OUTPUT_WIDTH)) u_asm (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (timeout_hit || (state == ST_IDLE)),
      .byte_valid (rx_valid && (state == ST_DATA)),
      .byte_data  (rx_data),
      .word_done  (wr_enable),
      .word       (wr_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      next_resp  = ACK;
      case (state)
         ST_IDLE:    if (rx_valid && (rx_data != 8'd0)) next_state = ST_TYPE;
         ST_TYPE:
            if (rx_valid) begin
               if ((rx_data == TYPE_WRITE) && write_len_ok)
                  next_state = ST_ADDR_HI;
               else if (((rx_data == TYPE_STEP) || (rx_data == TYPE_RANGE)) && (rem == 8'd3))
                  next_state = ST_CFG_HI;
               else if ((rx_data == TYPE_PING) && last_byte)
                  next_state = ST_RESP;
               else begin
                  next_resp  = NAK;
                  next_state = last_byte ? ST_RESP : ST_DRAIN;
               end
            end
         ST_ADDR_HI: if (rx_valid) next_state = ST_ADDR_LO;
         ST_ADDR_LO: if (rx_valid) next_state = ST_DATA;
         ST_DATA:    if (rx_valid && last_byte) next_state = ST_RESP;
         ST_CFG_HI:  if (rx_valid) next_state = ST_CFG_LO;
         ST_CFG_LO:  if (rx_valid) next_state = ST_RESP;
         ST_DRAIN:
            if (rx_valid && last_byte) begin
               next_resp  = NAK;
               next_state = ST_RESP;
            end
         ST_RESP:    if (tx_send) next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
      if (timeout_hit) begin
         next_resp  = NAK;
         next_state = ST_RESP;
      end
   end

   // The final word's write lands in the first RESP cycle; the send waits past it.
   always_comb begin
      tx_send = (state == ST_RESP) && !tx_busy && !wr_enable;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem       <= '0;
         idle_cnt  <= '0;
         addr_hi   <= '0;
         cfg_hi    <= '0;
         cfg_range <= 1'b0;
         wr_addr   <= '0;
         step      <= STEP_RST;
         range     <= RANGE_RST;
         tx_data   <= '0;
         overrun   <= 1'b0;
      end else begin
         if (rx_valid && (state == ST_IDLE))
            rem <= rx_data;
         else if (rx_valid && in_frame)
            rem <= rem - 8'd1;

         if (rx_valid || !in_frame) idle_cnt <= '0;
         else                       idle_cnt <= idle_cnt + 1'b1;

         if (rx_valid && (state == ST_TYPE))    cfg_range <= (rx_data == TYPE_RANGE);
         if (rx_valid && (state == ST_ADDR_HI)) addr_hi   <= rx_data[3:0];
         if (rx_valid && (state == ST_CFG_HI))  cfg_hi    <= rx_data[3:0];

         if (rx_valid && (state == ST_ADDR_LO)) wr_addr <= {addr_hi, rx_data};
         else if (wr_enable)                    wr_addr <= wr_addr + 12'd1;

         if (rx_valid && (state == ST_CFG_LO)) begin
            if (cfg_range) range <= {cfg_hi, rx_data};
            else           step  <= {cfg_hi, rx_data};
         end

         if ((next_state == ST_RESP) && (state != ST_RESP)) tx_data <= next_resp;
         if (rx_valid && (state == ST_RESP))                overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_comm_frame_ctrl.sv
// Scoreboard bench for comm_frame_ctrl: expected writes and response bytes
// are queued as frames are sent and checked when the DUT emits them.
module tb_comm_frame_ctrl;

   localparam int unsigned OW = 16;
   localparam int unsigned TO = 50;

   typedef struct {
      logic [11:0] addr;
      logic [15:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          tx_busy = 1'b0;
   logic          tx_send;
   logic [7:0]    tx_data;
   logic          wr_enable;
   logic [11:0]   wr_addr;
   logic [OW-1:0] wr_data;
   logic [11:0]   step;
   logic [11:0]   range;
   logic          overrun;

   int checks = 0;
   int errors = 0;
   wr_t        exp_wr[$];
   logic [7:0] exp_tx[$];
   logic       prev_wr = 1'b0;

   comm_frame_ctrl #(.OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_busy   (tx_busy),
      .tx_send   (tx_send),
      .tx_data   (tx_data),
      .wr_enable (wr_enable),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .step      (step),
      .range     (range),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Output monitor: pops the scoreboard whenever a write or send strobe appears.
   always @(negedge clk) begin
      wr_t e;
      logic [7:0] b;
      if (reset_n) begin
         if (wr_enable || tx_send) begin
            checks++;
            if (wr_enable && tx_send) begin
               errors++;
               $display("FAIL strobe_overlap: wr_enable=%b tx_send=%b, required not both", wr_enable, tx_send);
            end
         end
         if (wr_enable) begin
            checks++;
            if (prev_wr) begin
               errors++;
               $display("FAIL wr_pulse_width: wr_enable high two cycles, required one");
            end
            if (exp_wr.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: addr=%h data=%h, required no write", wr_addr, wr_data);
            end else begin
               e = exp_wr.pop_front();
               if (wr_addr !== e.addr || wr_data !== e.data) begin
                  errors++;
                  $display("FAIL wr_content: addr=%h data=%h, required addr=%h data=%h",
                           wr_addr, wr_data, e.addr, e.data);
               end
            end
         end
         if (tx_send) begin
            checks++;
            if (exp_tx.size() == 0) begin
               errors++;
               $display("FAIL tx_unexpected: tx_data=%h, required no send", tx_data);
            end else begin
               b = exp_tx.pop_front();
               if (tx_data !== b || tx_busy !== 1'b0) begin
                  errors++;
                  $display("FAIL tx_content: tx_data=%h tx_busy=%b, required tx_data=%h tx_busy=0",
                           tx_data, tx_busy, b);
               end
            end
         end
      end
      prev_wr = wr_enable;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 300; i++) begin
         if (exp_wr.size() == 0 && exp_tx.size() == 0) break;
         @(negedge clk);
      end
      checks++;
      if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: pending writes=%0d sends=%0d, required 0 and 0",
                  name, exp_wr.size(), exp_tx.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if (tx_send !== 1'b0 || tx_data !== 8'h00 || wr_enable !== 1'b0 || wr_addr !== 12'h000 ||
          wr_data !== 16'h0000 || step !== 12'h001 || range !== 12'hfff || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: send=%b txd=%h we=%b wa=%h wd=%h step=%h range=%h ovr=%b, required 0 00 0 000 0000 001 fff 0",
                  tx_send, tx_data, wr_enable, wr_addr, wr_data, step, range, overrun);
      end
   endtask

   task automatic test_write();
      logic [7:0] fr[8];
      fr = '{8'h07, 8'h01, 8'h0F, 8'hFE, 8'hAB, 8'hCD, 8'h12, 8'h34};
      exp_wr.push_back('{12'hFFE, 16'hABCD});
      exp_wr.push_back('{12'hFFF, 16'h1234});
      exp_tx.push_back(8'h06);
      tx_busy = 1'b1;
      foreach (fr[i]) send_byte(fr[i]);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (tx_send !== 1'b0) begin
            errors++;
            $display("FAIL write_hold_busy: tx_send=%b while tx_busy=1, required 0", tx_send);
         end
      end
      tx_busy = 1'b0;
      wait_drain("write");
      checks++;
      if (wr_addr !== 12'h000) begin
         errors++;
         $display("FAIL write_addr_after: wr_addr=%h, required 000", wr_addr);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] fa[6];
      logic [7:0] fc[8];
      fa = '{8'h05, 8'h01, 8'h0F, 8'hFF, 8'h00, 8'h01};
      exp_wr.push_back('{12'hFFF, 16'h0001});
      exp_tx.push_back(8'h06);
      foreach (fa[i]) send_byte(fa[i]);
      wait_drain("wrap_a");
      fa = '{8'h05, 8'h01, 8'h0F, 8'hFF, 8'h00, 8'h02};
      exp_wr.push_back('{12'hFFF, 16'h0002});
      exp_tx.push_back(8'h06);
      foreach (fa[i]) send_byte(fa[i]);
      wait_drain("wrap_b");
      checks++;
      if (wr_addr !== 12'h000) begin
         errors++;
         $display("FAIL wrap_addr_single: wr_addr=%h, required 000", wr_addr);
      end
      fc = '{8'h07, 8'h01, 8'h0F, 8'hFF, 8'h00, 8'h03, 8'h00, 8'h04};
      exp_wr.push_back('{12'hFFF, 16'h0003});
      exp_wr.push_back('{12'h000, 16'h0004});
      exp_tx.push_back(8'h06);
      foreach (fc[i]) send_byte(fc[i]);
      wait_drain("wrap_c");
      checks++;
      if (wr_addr !== 12'h001) begin
         errors++;
         $display("FAIL wrap_addr_burst: wr_addr=%h, required 001", wr_addr);
      end
   endtask

   task automatic test_config();
      exp_tx.push_back(8'h06);
      send_byte(8'h03); send_byte(8'h02); send_byte(8'h00);
      checks++;
      if (step !== 12'h001) begin
         errors++;
         $display("FAIL cfg_step_before_lo: step=%h, required 001", step);
      end
      send_byte(8'h10);
      checks++;
      if (step !== 12'h010 || range !== 12'hfff) begin
         errors++;
         $display("FAIL cfg_step_update: step=%h range=%h, required 010 fff", step, range);
      end
      wait_drain("cfg_step");
      exp_tx.push_back(8'h06);
      send_byte(8'h03); send_byte(8'h03); send_byte(8'h01); send_byte(8'h23);
      checks++;
      if (range !== 12'h123 || step !== 12'h010) begin
         errors++;
         $display("FAIL cfg_range_update: range=%h step=%h, required 123 010", range, step);
      end
      wait_drain("cfg_range");
   endtask

   task automatic test_invalid();
      logic [7:0] fa[5];
      fa = '{8'h04, 8'h09, 8'hAA, 8'hBB, 8'hCC};
      exp_tx.push_back(8'h15);
      foreach (fa[i]) send_byte(fa[i]);
      wait_drain("bad_type");
      exp_tx.push_back(8'h15);
      send_byte(8'h02); send_byte(8'h04); send_byte(8'h00);
      wait_drain("bad_ping_len");
      send_byte(8'h00);
      repeat (5) @(negedge clk);
      exp_tx.push_back(8'h06);
      send_byte(8'h01); send_byte(8'h04);
      wait_drain("len0_then_ping");
   endtask

   task automatic test_timeout();
      logic [7:0] fa[5];
      int cyc;
      logic got;
      fa = '{8'h05, 8'h01, 8'h00, 8'h10, 8'hAB};
      exp_tx.push_back(8'h15);
      foreach (fa[i]) send_byte(fa[i]);
      cyc = 0;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (tx_send) got = 1'b1;
      end
      checks++;
      if (!got || cyc != 49) begin
         errors++;
         $display("FAIL timeout_latency: seen=%b cycles=%0d, required seen=1 cycles=49", got, cyc);
      end
      wait_drain("timeout");
      exp_tx.push_back(8'h06);
      send_byte(8'h01); send_byte(8'h04);
      wait_drain("after_timeout");
   endtask

   task automatic test_overrun();
      tx_busy = 1'b1;
      exp_tx.push_back(8'h06);
      send_byte(8'h01); send_byte(8'h04);
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_before: overrun=%b, required 0", overrun);
      end
      send_byte(8'h55);
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set: overrun=%b, required 1", overrun);
      end
      tx_busy = 1'b0;
      wait_drain("overrun");
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] fa[7];
      fa = '{8'h07, 8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
      exp_wr.push_back('{12'h100, 16'hAABB});
      foreach (fa[i]) send_byte(fa[i]);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (tx_send !== 1'b0 || tx_data !== 8'h00 || wr_enable !== 1'b0 || wr_addr !== 12'h000 ||
          wr_data !== 16'h0000 || step !== 12'h001 || range !== 12'hfff || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_frame: send=%b txd=%h we=%b wa=%h wd=%h step=%h range=%h ovr=%b, required 0 00 0 000 0000 001 fff 0",
                  tx_send, tx_data, wr_enable, wr_addr, wr_data, step, range, overrun);
      end
      checks++;
      if (exp_wr.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_frame_write: pending writes=%0d, required 0", exp_wr.size());
         exp_wr.delete();
      end
      @(negedge clk);
      reset_n = 1'b1;
      exp_tx.push_back(8'h06);
      send_byte(8'h01); send_byte(8'h04);
      wait_drain("after_reset");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_write();
      test_wrap();
      test_config();
      test_invalid();
      test_timeout();
      test_overrun();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
